// File: rtl/conv_pkg.sv
// conv_pkg -- shared widths, coefficient array type and the reset kernel
// for the 3x3 convolution stage.
//   COEF_W : coefficient width (signed)
//   PIX_W  : pixel width (unsigned)
//   PROD_W : pixel x coefficient product width (signed)
//   ACC_W  : nine-product sum width (signed); wide enough that it cannot overflow
package conv_pkg;

  localparam int COEF_W = 8;
  localparam int PIX_W  = 8;
  localparam int PROD_W = 17;
  localparam int ACC_W  = 21;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t coef_arr_t [9];

  // Identity kernel: the centre tap equals 2^shift, so that the output
  // stage's shift gives unity gain. 2^7 and 2^8 do not fit in a signed
  // byte, so the centre tap saturates at 127 for those shifts.
  function automatic coef_arr_t identity_kernel(input int shift);
    coef_arr_t k;
    for (int i = 0; i < 9; i++) k[i] = '0;
    k[4] = (shift >= 7) ? coef_t'(127) : coef_t'(1 << shift);
    return k;
  endfunction

endpackage

// File: rtl/conv_round_clamp.sv
// conv_round_clamp -- adds a rounding offset, shifts arithmetically right
// and clamps the result to the unsigned pixel range. Purely combinational.
//   acc_i : signed accumulator (ACC_W bits)
//   pix_o : clamped pixel, 0..255
//   SHIFT : right-shift amount, 0..8 (no rounding offset when 0)
module conv_round_clamp
  import conv_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [PIX_W-1:0] pix_o
);

  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int RND    = (SHIFT > 0) ? (1 << RND_SH) : 0;

  // One guard bit keeps the rounding add from wrapping at the extremes.
  logic signed [ACC_W:0] acc_rnd;
  logic signed [ACC_W:0] acc_sh;

  always_comb begin
    acc_rnd = $signed({acc_i[ACC_W-1], acc_i}) + $signed((ACC_W+1)'(RND));
    acc_sh  = acc_rnd >>> SHIFT;
    if (acc_sh[ACC_W])
      pix_o = '0;
    else if (|acc_sh[ACC_W-1:PIX_W])
      pix_o = '1;
    else
      pix_o = acc_sh[PIX_W-1:0];
  end

endmodule

// File: rtl/conv3x3_stage.sv
// conv3x3_stage -- three-stage 3x3 convolution with programmable signed
// coefficients, rounding/clamping output and raster position tracking.
//   clk, rst       : clock, async active-high reset
//   enable         : low flushes in-flight windows and the position counters
//   win, win_valid : unsigned 3x3 window (win[row][col]) and its strobe
//   coef_we/addr/data : coefficient write port, row-major index 0..8
//   pix, pix_valid : output pixel and its strobe (pix holds between strobes)
//   pix_row/col    : raster position of pix
//   frame_done     : pulses with the last pixel of a frame
module conv3x3_stage
  import conv_pkg::*;
#(
  parameter int ROWS  = 512,
  parameter int COLS  = 512,
  parameter int SHIFT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [2:0][2:0][7:0]      win,
  input  logic                      win_valid,
  input  logic                      coef_we,
  input  logic [3:0]                coef_addr,
  input  logic [7:0]                coef_data,
  output logic [7:0]                pix,
  output logic                      pix_valid,
  output logic [$clog2(ROWS)-1:0]   pix_row,
  output logic [$clog2(COLS)-1:0]   pix_col,
  output logic                      frame_done
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  coef_arr_t                 coef_q;
  logic signed [PROD_W-1:0]  prod_d [9];
  logic signed [PROD_W-1:0]  prod_q [9];
  logic signed [ACC_W-1:0]   sum_d, sum_q;
  logic                      v1_q, v2_q;
  logic [PIX_W-1:0]          rc_pix;
  logic [PIX_W-1:0]          pix_q;
  logic                      pix_valid_q, frame_done_q;
  logic [RW-1:0]             row_q, row_d, pix_row_q;
  logic [CW-1:0]             col_q, col_d, pix_col_q;
  logic                      last_px;

  // Coefficients survive enable=0; only reset reloads the identity kernel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      coef_q <= identity_kernel(SHIFT);
    else if (coef_we && coef_addr <= 4'd8)
      coef_q[coef_addr] <= coef_data;
  end

  // Stage 1 uses the coefficients registered before this edge, so a write
  // landing with a window only affects later windows.
  always_comb begin
    for (int i = 0; i < 9; i++)
      prod_d[i] = PROD_W'($signed({1'b0, win[i/3][i%3]})) * PROD_W'(coef_q[i]);
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 9; i++) sum_d = sum_d + ACC_W'(prod_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      sum_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
    end else begin
      v1_q <= enable & win_valid;
      v2_q <= enable & v1_q;
      if (enable && win_valid)
        for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      if (enable && v1_q)
        sum_q <= sum_d;
    end
  end

  conv_round_clamp #(.SHIFT(SHIFT)) u_round_clamp (
    .acc_i (sum_q),
    .pix_o (rc_pix)
  );

  assign last_px = (row_q == RW'(ROWS-1)) && (col_q == CW'(COLS-1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (col_q == CW'(COLS-1)) begin
      col_d = '0;
      row_d = last_px ? '0 : row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  // row_q/col_q track the position of the next pixel; pix_row/pix_col hold
  // the position of the pixel currently on pix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q        <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      pix_row_q    <= '0;
      pix_col_q    <= '0;
    end else if (!enable) begin
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
    end else begin
      pix_valid_q  <= v2_q;
      frame_done_q <= v2_q & last_px;
      if (v2_q) begin
        pix_q     <= rc_pix;
        pix_row_q <= row_q;
        pix_col_q <= col_q;
        row_q     <= row_d;
        col_q     <= col_d;
      end
    end
  end

  assign pix        = pix_q;
  assign pix_valid  = pix_valid_q;
  assign pix_row    = pix_row_q;
  assign pix_col    = pix_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_stage.sv
module tb_conv3x3_stage;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic                 clk = 1'b0;
  logic                 rst, enable, win_valid, coef_we;
  logic [2:0][2:0][7:0] win;
  logic [3:0]           coef_addr;
  logic [7:0]           coef_data;

  logic [7:0] pix_a, pix_b;
  logic       pv_a, pv_b, fd_a, fd_b;
  logic [1:0] row_a, col_a, row_b, col_b;

  conv3x3_stage #(.ROWS(ROWS), .COLS(COLS), .SHIFT(4)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .win(win), .win_valid(win_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .pix(pix_a), .pix_valid(pv_a), .pix_row(row_a), .pix_col(col_a),
    .frame_done(fd_a));

  conv3x3_stage #(.ROWS(ROWS), .COLS(COLS), .SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .win(win), .win_valid(win_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .pix(pix_b), .pix_valid(pv_b), .pix_row(row_b), .pix_col(col_b),
    .frame_done(fd_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: both DUTs see the same stream, so one queue of
  // expected outputs carries the result for each shift setting.
  typedef struct {
    int due;
    int pa;
    int pb;
    int row;
    int col;
    int fd;
  } exp_t;

  exp_t q_exp[$];
  int   mc_a[9];
  int   mc_b[9];
  int   pos_r, pos_c;
  int   lp_a, lp_b, l_row, l_col;

  function automatic int ref_pix(input logic [2:0][2:0][7:0] w, input int k[9],
                                 input int sh);
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) s += int'(w[i/3][i%3]) * k[i];
    if (sh > 0) s += 1 << (sh - 1);
    s = s >>> sh;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic model_identity();
    for (int i = 0; i < 9; i++) begin
      mc_a[i] = 0;
      mc_b[i] = 0;
    end
    mc_a[4] = 16;
    mc_b[4] = 1;
  endtask

  task automatic model_write(input int a, input int d);
    logic signed [7:0] sd;
    logic [31:0]       dv;
    dv = d;
    sd = dv[7:0];
    if (a <= 8) begin
      mc_a[a] = int'(sd);
      mc_b[a] = int'(sd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0][2:0][7:0] w, input bit we,
                      input int a, input int d);
    exp_t e;
    win       = w;
    win_valid = 1'b1;
    coef_we   = we;
    coef_addr = 4'(a);
    coef_data = 8'(d);
    e.due = cyc + 3;
    e.pa  = ref_pix(w, mc_a, 4);
    e.pb  = ref_pix(w, mc_b, 0);
    e.row = pos_r;
    e.col = pos_c;
    e.fd  = (pos_r == ROWS-1 && pos_c == COLS-1) ? 1 : 0;
    q_exp.push_back(e);
    if (pos_c == COLS-1) begin
      pos_c = 0;
      pos_r = (pos_r == ROWS-1) ? 0 : pos_r + 1;
    end else begin
      pos_c++;
    end
    if (we) model_write(a, d);
    tick();
    win_valid = 1'b0;
    coef_we   = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = 4'(a);
    coef_data = 8'(d);
    model_write(a, d);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Outputs already produced at this edge stand; anything later is killed.
  task automatic flush_enable();
    enable = 1'b0;
    while (q_exp.size() > 0 && q_exp[$].due > cyc) void'(q_exp.pop_back());
    pos_r = 0;
    pos_c = 0;
    tick();
    enable = 1'b1;
  endtask

  // Async reset also wipes the pixel already presented at this edge.
  task automatic pulse_rst();
    rst = 1'b1;
    while (q_exp.size() > 0 && q_exp[$].due >= cyc) void'(q_exp.pop_back());
    pos_r = 0;
    pos_c = 0;
    lp_a = 0;
    lp_b = 0;
    l_row = 0;
    l_col = 0;
    model_identity();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [2:0][2:0][7:0] flat_win(input int v);
    logic [2:0][2:0][7:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r][c] = 8'(v);
    return w;
  endfunction

  function automatic logic [2:0][2:0][7:0] ring_win(input int ctr, input int nb);
    logic [2:0][2:0][7:0] w;
    w = flat_win(nb);
    w[1][1] = 8'(ctr);
    return w;
  endfunction

  function automatic logic [2:0][2:0][7:0] rand_win();
    logic [2:0][2:0][7:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r][c] = 8'($urandom);
    return w;
  endfunction

  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    exp_v = (q_exp.size() > 0) && (q_exp[0].due == cyc);
    chk("pix_valid a", int'(pv_a), int'(exp_v));
    chk("pix_valid b", int'(pv_b), int'(exp_v));
    if (exp_v) begin
      e = q_exp.pop_front();
      chk("pix a", int'(pix_a), e.pa);
      chk("pix b", int'(pix_b), e.pb);
      chk("row a", int'(row_a), e.row);
      chk("col a", int'(col_a), e.col);
      chk("row b", int'(row_b), e.row);
      chk("col b", int'(col_b), e.col);
      chk("frame_done a", int'(fd_a), e.fd);
      chk("frame_done b", int'(fd_b), e.fd);
      lp_a  = e.pa;
      lp_b  = e.pb;
      l_row = e.row;
      l_col = e.col;
    end else begin
      chk("hold pix a", int'(pix_a), lp_a);
      chk("hold pix b", int'(pix_b), lp_b);
      chk("hold row", int'(row_a), l_row);
      chk("hold col", int'(col_b), l_col);
      chk("idle frame_done", int'(fd_a | fd_b), 0);
    end
  end

  initial begin
    int r;
    rst       = 1'b1;
    enable    = 1'b1;
    win_valid = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    win       = '0;
    pos_r = 0; pos_c = 0;
    lp_a = 0; lp_b = 0; l_row = 0; l_col = 0;
    model_identity();
    idle(3);
    chk("reset pix", int'(pix_a), 0);
    chk("reset pix_valid", int'(pv_a | pv_b), 0);
    chk("reset row/col", int'(row_a) + int'(col_a), 0);
    rst = 1'b0;

    // Identity kernel, flat 200 window issued at cycle 10 -> 200 at cycle 13.
    while (cyc < 10) tick();
    send(flat_win(200), 0, 0, 0);
    idle(5);

    // All +1 then all -1, flat 255 window.
    for (int i = 0; i < 9; i++) wr(i, 1);
    send(flat_win(255), 0, 0, 0);
    idle(4);
    for (int i = 0; i < 9; i++) wr(i, 8'hFF);
    send(flat_win(255), 0, 0, 0);
    idle(4);

    // Writes to addresses 9..15 must be ignored.
    for (int i = 9; i < 16; i++) wr(i, 8'h55);
    send(rand_win(), 0, 0, 0);
    idle(4);

    // Full 4x4 frame back to back from a cleared position, then one more.
    for (int i = 0; i < 9; i++) wr(i, $urandom_range(0, 255));
    flush_enable();
    for (int i = 0; i < ROWS*COLS; i++) send(rand_win(), 0, 0, 0);
    send(rand_win(), 0, 0, 0);
    idle(5);

    // Coefficient write coinciding with a window.
    for (int i = 0; i < 9; i++) wr(i, 0);
    wr(4, 16);
    send(ring_win(100, 0), 1, 4, 0);
    send(ring_win(100, 0), 0, 0, 0);
    idle(5);

    // enable drop one cycle after two windows; coefficients must survive.
    wr(4, 16);
    send(rand_win(), 0, 0, 0);
    send(rand_win(), 0, 0, 0);
    flush_enable();
    idle(5);
    send(ring_win(77, 33), 0, 0, 0);
    idle(5);

    // Reset one cycle after two windows.
    wr(0, 5);
    send(rand_win(), 0, 0, 0);
    send(rand_win(), 0, 0, 0);
    pulse_rst();
    idle(5);
    send(ring_win(123, 45), 0, 0, 0);
    idle(5);

    // Laplacian kernel.
    for (int i = 0; i < 9; i++) wr(i, 8'hFF);
    wr(4, 8);
    send(ring_win(10, 9), 0, 0, 0);
    send(ring_win(0, 50), 0, 0, 0);
    idle(5);

    // Randomised traffic.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        if ($urandom_range(0, 4) == 0)
          send(rand_win(), 1, $urandom_range(0, 15), $urandom_range(0, 255));
        else
          send(rand_win(), 0, 0, 0);
      end else if (r < 80) begin
        wr($urandom_range(0, 15), $urandom_range(0, 255));
      end else if (r < 86) begin
        idle($urandom_range(1, 3));
      end else if (r < 92) begin
        flush_enable();
      end else if (r < 94) begin
        pulse_rst();
      end else begin
        idle(1);
      end
    end

    idle(8);
    chk("drained", q_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
